// File: rtl/ghost_mover.sv
// ghost_mover
//   Turns the one-hot steering request into pixel motion on a tile grid. Owns
//   the ghost x/y position and the last committed direction, both of which
//   are fed back to the steering logic. A new direction is accepted only when
//   the ghost sits exactly on a tile. Handles screen wrap-around, a
//   post-respawn hold period and a global enable.
//
//   Optional feature macro: GHOST_FRIGHTENED_EN
//     Adds the `frightened` input. While it is high, the ghost moves at half
//     speed. A rising edge while MOVING reverses the direction of travel.
//
// Ports
//   clk              system clock
//   rst              synchronous reset, active-high
//   enable           1 = motion allowed, 0 = freeze state and tick counter
//   respawn          single-cycle pulse, return home and hold
//   frightened       (GHOST_FRIGHTENED_EN only) half speed, reverse on rise
//   move_direction   one-hot request: RIGHT=0001 UP=0010 DOWN=0100 LEFT=1000
//   valid_moves      open directions at the current position, same encoding
//   ghost_curr_pos_x current x pixel
//   ghost_curr_pos_y current y pixel
//   prev_direction   direction of the last committed step, 0000 = none
//   tile_aligned     x and y are both multiples of TILE
//   moving           FSM is in MOVING
module ghost_mover #(
  parameter logic [10:0] START_X    = 11'd320,
  parameter logic [9:0]  START_Y    = 10'd240,
  parameter int          TILE       = 16,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          STEP_DIV   = 250000,
  parameter int          HOLD_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        respawn,
`ifdef GHOST_FRIGHTENED_EN
  input  logic        frightened,
`endif
  input  logic [3:0]  move_direction,
  input  logic [3:0]  valid_moves,
  output logic [10:0] ghost_curr_pos_x,
  output logic [9:0]  ghost_curr_pos_y,
  output logic [3:0]  prev_direction,
  output logic        tile_aligned,
  output logic        moving
);

  localparam int TCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TCW-1:0] TICK_LAST = TCW'(STEP_DIV - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TICKS - 1);
  localparam logic [10:0]    X_MAX     = 11'(SCREEN_W - 1);
  localparam logic [9:0]     Y_MAX     = 10'(SCREEN_H - 1);
  localparam logic [10:0]    X_MASK    = 11'(TILE - 1);
  localparam logic [9:0]     Y_MASK    = 10'(TILE - 1);

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    MOVING  = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [10:0]    x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [3:0]     prev_q, prev_d;
  logic [3:0]     cur_q, cur_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [TCW-1:0] tick_cnt;
  logic           tick;
  logic           step_tick;
  logic           legal;
  logic           reverse;

  // One pixel in direction d, wrapping at the screen edges.
  function automatic logic [10:0] step_x(input logic [10:0] x, input logic [3:0] d);
    if (d == DIR_RIGHT) return (x == X_MAX) ? 11'd0 : x + 11'd1;
    if (d == DIR_LEFT)  return (x == 11'd0) ? X_MAX : x - 11'd1;
    return x;
  endfunction

  function automatic logic [9:0] step_y(input logic [9:0] y, input logic [3:0] d);
    if (d == DIR_DOWN) return (y == Y_MAX) ? 10'd0 : y + 10'd1;
    if (d == DIR_UP)   return (y == 10'd0) ? Y_MAX : y - 10'd1;
    return y;
  endfunction

  function automatic logic on_tile(input logic [10:0] x, input logic [9:0] y);
    return ((x & X_MASK) == 11'd0) && ((y & Y_MASK) == 10'd0);
  endfunction

  // ---------------------------------------------------------------------------
  // Step timebase: one tick per STEP_DIV enabled cycles.
  // ---------------------------------------------------------------------------
  assign tick = enable && (tick_cnt == TICK_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TCW'(1);
    end
  end

`ifdef GHOST_FRIGHTENED_EN
  logic fright_q;   // frightened delayed, for rising-edge detection
  logic half_phase; // alternates per tick while frightened; step on 1

  always_ff @(posedge clk) begin
    if (rst) begin
      fright_q   <= 1'b0;
      half_phase <= 1'b0;
    end else if (enable) begin
      fright_q <= frightened;
      if (!frightened)
        half_phase <= 1'b0;
      else if (tick)
        half_phase <= ~half_phase;
    end
  end

  assign step_tick = tick && (!frightened || half_phase);
  // The edge is only acted on while enabled so a freeze cannot swallow or
  // duplicate the reversal.
  assign reverse   = enable && frightened && !fright_q && (state_q == MOVING);
`else
  assign step_tick = tick;
  assign reverse   = 1'b0;
`endif

  // A request counts only if it is exactly one-hot and points into an open
  // direction.
  assign legal = (move_direction != 4'b0000)
              && ((move_direction & (move_direction - 4'd1)) == 4'b0000)
              && ((move_direction & valid_moves) != 4'b0000);

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      default:   return d;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: respawn > reversal > step tick.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold-value default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    hold_d  = hold_q;

    if (respawn) begin
      x_d     = START_X;
      y_d     = START_Y;
      prev_d  = 4'b0000;
      hold_d  = '0;
      state_d = RESPAWN;
    end else if (reverse) begin
      cur_d  = opposite(cur_q);
      prev_d = opposite(prev_q);
    end else if (step_tick) begin
      case (state_q)
        ALIGNED: begin
          if (legal) begin
            cur_d   = move_direction;
            prev_d  = move_direction;
            x_d     = step_x(x_q, move_direction);
            y_d     = step_y(y_q, move_direction);
            state_d = MOVING;
          end else if ((prev_q & valid_moves) != 4'b0000) begin
            // Keep going the way we came if that corridor is still open.
            cur_d   = prev_q;
            x_d     = step_x(x_q, prev_q);
            y_d     = step_y(y_q, prev_q);
            state_d = MOVING;
          end
        end
        MOVING: begin
          x_d = step_x(x_q, cur_q);
          y_d = step_y(y_q, cur_q);
          if (on_tile(x_d, y_d))
            state_d = ALIGNED;
        end
        RESPAWN: begin
          if (hold_q == HOLD_LAST)
            state_d = ALIGNED;
          else
            hold_d = hold_q + HCW'(1);
        end
        default: state_d = ALIGNED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIGNED;
      x_q     <= START_X;
      y_q     <= START_Y;
      prev_q  <= 4'b0000;
      cur_q   <= 4'b0000;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
    end
  end

  assign ghost_curr_pos_x = x_q;
  assign ghost_curr_pos_y = y_q;
  assign prev_direction   = prev_q;
  assign tile_aligned     = on_tile(x_q, y_q);
  assign moving           = (state_q == MOVING);

endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover
//   Self-checking bench for ghost_mover (STEP_DIV=2, TILE=16, start 320,240).
//   A behavioural reference model predicts the registered outputs for every
//   clock; the prediction is queued when the inputs are driven and compared
//   after the edge. Directed scenarios add fixed-value checkpoints.
//   Define GHOST_FRIGHTENED_EN for both files to exercise the optional feature.
module tb_ghost_mover;

  localparam int SD   = 2;
  localparam int T    = 16;
  localparam int W    = 640;
  localparam int H    = 480;
  localparam int SX   = 320;
  localparam int SY   = 240;
  localparam int HOLD = 64;

  localparam logic [3:0] R   = 4'b0001;
  localparam logic [3:0] U   = 4'b0010;
  localparam logic [3:0] L   = 4'b1000;
  localparam logic [3:0] ALL = 4'b1111;

  localparam int S_AL  = 0;
  localparam int S_MOV = 1;
  localparam int S_RSP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        respawn;
  logic [3:0]  move_direction;
  logic [3:0]  valid_moves;
  logic [10:0] ghost_curr_pos_x;
  logic [9:0]  ghost_curr_pos_y;
  logic [3:0]  prev_direction;
  logic        tile_aligned;
  logic        moving;
`ifdef GHOST_FRIGHTENED_EN
  logic        frightened = 1'b0;
`endif

  ghost_mover #(
    .START_X   (11'd320),
    .START_Y   (10'd240),
    .TILE      (T),
    .SCREEN_W  (W),
    .SCREEN_H  (H),
    .STEP_DIV  (SD),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .respawn         (respawn),
`ifdef GHOST_FRIGHTENED_EN
    .frightened      (frightened),
`endif
    .move_direction  (move_direction),
    .valid_moves     (valid_moves),
    .ghost_curr_pos_x(ghost_curr_pos_x),
    .ghost_curr_pos_y(ghost_curr_pos_y),
    .prev_direction  (prev_direction),
    .tile_aligned    (tile_aligned),
    .moving          (moving)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         m_x, m_y, m_state, m_tick, m_hold;
  logic [3:0] m_prev, m_cur;
  bit         m_fq, m_ph, m_last_tick;

  typedef struct {
    int         x;
    int         y;
    logic [3:0] prev;
    bit         mov;
    bit         al;
  } exp_t;

  exp_t sb[$];

  task automatic move_m(input logic [3:0] d);
    case (d)
      4'b0001: m_x = (m_x + 1) % W;
      4'b1000: m_x = (m_x + W - 1) % W;
      4'b0100: m_y = (m_y + 1) % H;
      4'b0010: m_y = (m_y + H - 1) % H;
      default: ;
    endcase
  endtask

  // Predicts the register values after the coming edge from current inputs.
  task automatic model_edge();
    bit tk, st, rev, lg;
    bit fr;
    fr = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
    fr = frightened;
`endif
    tk  = enable && (m_tick == SD - 1);
    st  = tk && (!fr || m_ph);
    rev = enable && fr && !m_fq && (m_state == S_MOV);
    m_last_tick = tk;
    if (rst) begin
      m_x = SX; m_y = SY; m_prev = 4'b0; m_cur = 4'b0; m_state = S_AL;
      m_tick = 0; m_hold = 0; m_fq = 1'b0; m_ph = 1'b0;
      return;
    end
    if (enable) begin
      m_tick = tk ? 0 : m_tick + 1;
      if (!fr) m_ph = 1'b0;
      else if (tk) m_ph = !m_ph;
      m_fq = fr;
    end
    if (respawn) begin
      m_x = SX; m_y = SY; m_prev = 4'b0; m_hold = 0; m_state = S_RSP;
    end else if (rev) begin
      m_cur  = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
      m_prev = {m_prev[0], m_prev[1], m_prev[2], m_prev[3]};
    end else if (st) begin
      if (m_state == S_AL) begin
        lg = ($countones(move_direction) == 1) && ((move_direction & valid_moves) != 4'b0);
        if (lg) begin
          m_cur = move_direction; m_prev = move_direction;
          move_m(m_cur); m_state = S_MOV;
        end else if ((m_prev & valid_moves) != 4'b0) begin
          m_cur = m_prev;
          move_m(m_cur); m_state = S_MOV;
        end
      end else if (m_state == S_MOV) begin
        move_m(m_cur);
        if ((m_x % T == 0) && (m_y % T == 0)) m_state = S_AL;
      end else begin
        if (m_hold == HOLD - 1) m_state = S_AL;
        else m_hold++;
      end
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("x",       int'(ghost_curr_pos_x), e.x);
    check("y",       int'(ghost_curr_pos_y), e.y);
    check("prev",    int'(prev_direction),   int'(e.prev));
    check("moving",  int'(moving),           int'(e.mov));
    check("aligned", int'(tile_aligned),     int'(e.al));
  endtask

  // Drive one cycle of inputs, queue the prediction, compare after the edge.
  task automatic cycle(input bit e, input bit r, input logic [3:0] md, input logic [3:0] vm);
    exp_t ex;
    enable = e; respawn = r; move_direction = md; valid_moves = vm;
    model_edge();
    ex.x = m_x; ex.y = m_y; ex.prev = m_prev;
    ex.mov = (m_state == S_MOV);
    ex.al  = (m_x % T == 0) && (m_y % T == 0);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    rst = 1'b1; enable = 1'b0; respawn = 1'b0;
    move_direction = 4'b0; valid_moves = 4'b0;
    @(posedge clk); #1;
    repeat (2) cycle(1'b0, 1'b0, 4'b0, 4'b0);
    check("rst_x", int'(ghost_curr_pos_x), 320);
    check("rst_y", int'(ghost_curr_pos_y), 240);
    check("rst_prev", int'(prev_direction), 0);
    check("rst_moving", int'(moving), 0);
    rst = 1'b0;

    // Legal RIGHT from home: first step on the 2nd cycle, aligned after 32.
    repeat (2) cycle(1'b1, 1'b0, R, ALL);
    check("s1_x321", int'(ghost_curr_pos_x), 321);
    check("s1_moving", int'(moving), 1);
    check("s1_prev", int'(prev_direction), int'(R));
    repeat (30) cycle(1'b1, 1'b0, R, ALL);
    check("s1_x336", int'(ghost_curr_pos_x), 336);
    check("s1_aligned", int'(tile_aligned), 1);
    check("s1_not_moving", int'(moving), 0);

    // Illegal UP request: keep going RIGHT.
    repeat (2) cycle(1'b1, 1'b0, U, R);
    check("s2_x337", int'(ghost_curr_pos_x), 337);
    check("s2_prev", int'(prev_direction), int'(R));
    repeat (30) cycle(1'b1, 1'b0, U, R);

    // Head LEFT all the way to x=0, then wrap.
    for (int i = 0; i < 1000; i++) begin
      if (m_x == 0 && m_state == S_AL) break;
      cycle(1'b1, 1'b0, L, ALL);
    end
    check("s3_at_x0", int'(ghost_curr_pos_x), 0);
    repeat (2) cycle(1'b1, 1'b0, L, L);
    check("s3_wrap_x639", int'(ghost_curr_pos_x), 639);
    repeat (30) cycle(1'b1, 1'b0, L, L);
    check("s3_x624", int'(ghost_curr_pos_x), 624);
    check("s3_aligned", int'(tile_aligned), 1);

    // Respawn home, then travel to x=329 and respawn mid-tile.
    cycle(1'b1, 1'b1, R, ALL);
    for (int i = 0; i < 600; i++) begin
      if (m_x == 329 && m_state == S_MOV) break;
      cycle(1'b1, 1'b0, R, ALL);
    end
    check("s4_at_x329", int'(ghost_curr_pos_x), 329);
    check("s4_moving", int'(moving), 1);
    cycle(1'b1, 1'b1, R, ALL);
    check("s4_rsp_x", int'(ghost_curr_pos_x), 320);
    check("s4_rsp_y", int'(ghost_curr_pos_y), 240);
    check("s4_rsp_prev", int'(prev_direction), 0);
    nt = 0;
    for (int i = 0; i < 400 && nt < HOLD; i++) begin
      cycle(1'b1, 1'b0, R, ALL);
      if (m_last_tick) nt++;
    end
    check("s4_hold_x", int'(ghost_curr_pos_x), 320);
    check("s4_hold_moving", int'(moving), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, R, ALL);
      if (m_last_tick) break;
    end
    check("s4_tick65_x", int'(ghost_curr_pos_x), 321);
    check("s4_tick65_moving", int'(moving), 1);

    // Freeze mid-tile for 10 cycles, between ticks.
    for (int i = 0; i < 20; i++) begin
      if (m_x == 324) break;
      cycle(1'b1, 1'b0, R, ALL);
    end
    cycle(1'b1, 1'b0, R, ALL);
    repeat (10) cycle(1'b0, 1'b0, U, U);
    check("s5_frozen_x", int'(ghost_curr_pos_x), 324);
    check("s5_frozen_moving", int'(moving), 1);
    cycle(1'b1, 1'b0, R, ALL);
    check("s5_resume_x", int'(ghost_curr_pos_x), 325);

`ifdef GHOST_FRIGHTENED_EN
    // Frightened rises while MOVING right at x=325: reverse, then half speed.
    frightened = 1'b1;
    cycle(1'b1, 1'b0, R, ALL);
    check("f_prev_left", int'(prev_direction), int'(L));
    check("f_x_hold", int'(ghost_curr_pos_x), 325);
    repeat (16) cycle(1'b1, 1'b0, R, ALL);
    check("f_half_speed_x", int'(ghost_curr_pos_x), 321);
    frightened = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
`ifdef GHOST_FRIGHTENED_EN
      if ($urandom_range(0, 39) == 0) frightened = !frightened;
`endif
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of activity.
    rst = 1'b1;
    cycle(1'b1, 1'b0, R, ALL);
    rst = 1'b0;
    check("rst2_x", int'(ghost_curr_pos_x), 320);
    check("rst2_prev", int'(prev_direction), 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
